// File: rtl/matrix_address_sequencer_if.sv
// ---------------------------------------------------------------------------
// matrix_address_sequencer_if
// Address-beat bus between the matrix address sequencer and its consumer.
//   valid   : beat present (producer -> consumer)
//   address : generated memory address
//   op_type : operand tag echoed with every beat
//   last    : final beat of the tile walk
//   ready   : consumer accepts the beat this cycle (consumer -> producer)
// A beat transfers on a rising edge where valid & ready.
// ---------------------------------------------------------------------------
interface matrix_address_sequencer_if #(
  parameter int ADDR_WIDTH = 10,
  parameter int TYPE_WIDTH = 3
);
  logic                  valid;
  logic [ADDR_WIDTH-1:0] address;
  logic [TYPE_WIDTH-1:0] op_type;
  logic                  last;
  logic                  ready;

  modport master (
    output valid,
    output address,
    output op_type,
    output last,
    input  ready
  );

  modport slave (
    input  valid,
    input  address,
    input  op_type,
    input  last,
    output ready
  );
endinterface

// File: rtl/matrix_address_sequencer.sv
// ---------------------------------------------------------------------------
// matrix_address_sequencer
// Walks a rectangular tile of a row-strided matrix and emits one memory
// address per cycle on a valid/ready bus.
//   address = Base + (Row_Index + r) * Stride + (Column_Index + c)
// Row-major walks advance c fastest, column-major walks advance r fastest.
//
// Ports:
//   i_Clock, i_Reset_n        : clock, asynchronous active-low reset
//   i_Start, i_Abort          : start a walk (only when o_Ready) / cut it short
//   i_Col_Major, i_Base, i_Stride, i_Row_Index, i_Column_Index,
//   i_Num_Rows, i_Num_Cols, i_Type : walk description, latched at start
//   beat (master)             : valid/address/op_type/last out, ready in
//   o_Ready                   : idle, start may be accepted
//   o_Done                    : one-cycle pulse when a walk ends (normal/abort)
//   o_Overflow                : sticky flag, a transferred beat wrapped
//
// Optional feature: define MATRIX_ADDR_OVERFLOW_CHECK_EN to compute the
// address at full precision and flag wrapped beats on o_Overflow. Without it
// the address wraps silently and o_Overflow is constant 0.
// ---------------------------------------------------------------------------
module matrix_address_sequencer #(
  parameter int INDEX_WIDTH = 8,
  parameter int ADDR_WIDTH  = 10,
  parameter int TYPE_WIDTH  = 3
) (
  input  logic                   i_Clock,
  input  logic                   i_Reset_n,
  input  logic                   i_Start,
  input  logic                   i_Abort,
  input  logic                   i_Col_Major,
  input  logic [ADDR_WIDTH-1:0]  i_Base,
  input  logic [INDEX_WIDTH-1:0] i_Stride,
  input  logic [INDEX_WIDTH-1:0] i_Row_Index,
  input  logic [INDEX_WIDTH-1:0] i_Column_Index,
  input  logic [INDEX_WIDTH-1:0] i_Num_Rows,
  input  logic [INDEX_WIDTH-1:0] i_Num_Cols,
  input  logic [TYPE_WIDTH-1:0]  i_Type,
  matrix_address_sequencer_if.master beat,
  output logic                   o_Ready,
  output logic                   o_Done,
  output logic                   o_Overflow
);

  // One extra bit so an extent of 2^INDEX_WIDTH-1 never wraps the counters.
  localparam int CW = INDEX_WIDTH + 1;

`ifdef MATRIX_ADDR_OVERFLOW_CHECK_EN
  // Wide enough for (origin + counter) * stride + origin + counter + base.
  localparam int CALC_W = ((2*INDEX_WIDTH + 2 > ADDR_WIDTH) ?
                           2*INDEX_WIDTH + 2 : ADDR_WIDTH) + 2;
`else
  localparam int CALC_W = ADDR_WIDTH;
`endif

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  base_q;
  logic [INDEX_WIDTH-1:0] stride_q;
  logic [INDEX_WIDTH-1:0] row_q;
  logic [INDEX_WIDTH-1:0] col_q;
  logic [INDEX_WIDTH-1:0] nr_q;
  logic [INDEX_WIDTH-1:0] nc_q;
  logic                   col_major_q;
  logic [CW-1:0]          r_q;
  logic [CW-1:0]          c_q;

  logic [CW-1:0]          r_max;
  logic [CW-1:0]          c_max;
  logic [CW-1:0]          r_nxt;
  logic [CW-1:0]          c_nxt;
  logic                   last_nxt;
  logic [CALC_W-1:0]      nxt_full;
  logic [CALC_W-1:0]      start_full;

`ifdef MATRIX_ADDR_OVERFLOW_CHECK_EN
  // Bits above ADDR_WIDTH of the beat currently on the bus.
  logic [CALC_W-ADDR_WIDTH-1:0] addr_hi_q;
`endif

  // Address arithmetic is modulo 2^CALC_W; with CALC_W == ADDR_WIDTH this
  // is exactly the silent wrap of the output address.
  function automatic logic [CALC_W-1:0] calc_addr(
    input logic [ADDR_WIDTH-1:0]  base,
    input logic [INDEX_WIDTH-1:0] stride,
    input logic [INDEX_WIDTH-1:0] row,
    input logic [INDEX_WIDTH-1:0] col,
    input logic [CW-1:0]          r,
    input logic [CW-1:0]          c
  );
    logic [CALC_W-1:0] row_sum;
    logic [CALC_W-1:0] prod;
    row_sum = CALC_W'(row) + CALC_W'(r);
    prod    = row_sum * CALC_W'(stride);
    return CALC_W'(base) + prod + CALC_W'(col) + CALC_W'(c);
  endfunction

  // Position and address of the beat that follows the one on the bus.
  always_comb begin
    r_max = CW'(nr_q) - CW'(1);
    c_max = CW'(nc_q) - CW'(1);
    r_nxt = r_q;
    c_nxt = c_q;
    if (!col_major_q) begin
      if (c_q == c_max) begin
        c_nxt = '0;
        r_nxt = r_q + CW'(1);
      end else begin
        c_nxt = c_q + CW'(1);
      end
    end else begin
      if (r_q == r_max) begin
        r_nxt = '0;
        c_nxt = c_q + CW'(1);
      end else begin
        r_nxt = r_q + CW'(1);
      end
    end
    last_nxt   = (r_nxt == r_max) && (c_nxt == c_max);
    nxt_full   = calc_addr(base_q, stride_q, row_q, col_q, r_nxt, c_nxt);
    start_full = calc_addr(i_Base, i_Stride, i_Row_Index, i_Column_Index,
                           '0, '0);
  end

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state        <= S_IDLE;
      o_Ready      <= 1'b1;
      o_Done       <= 1'b0;
      beat.valid   <= 1'b0;
      beat.address <= '0;
      beat.op_type <= '0;
      beat.last    <= 1'b0;
      base_q       <= '0;
      stride_q     <= '0;
      row_q        <= '0;
      col_q        <= '0;
      nr_q         <= '0;
      nc_q         <= '0;
      col_major_q  <= 1'b0;
      r_q          <= '0;
      c_q          <= '0;
`ifdef MATRIX_ADDR_OVERFLOW_CHECK_EN
      addr_hi_q    <= '0;
      o_Overflow   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          o_Done <= 1'b0;
          if (i_Start) begin
            base_q       <= i_Base;
            stride_q     <= i_Stride;
            row_q        <= i_Row_Index;
            col_q        <= i_Column_Index;
            nr_q         <= i_Num_Rows;
            nc_q         <= i_Num_Cols;
            col_major_q  <= i_Col_Major;
            beat.op_type <= i_Type;
            r_q          <= '0;
            c_q          <= '0;
            o_Ready      <= 1'b0;
`ifdef MATRIX_ADDR_OVERFLOW_CHECK_EN
            o_Overflow   <= 1'b0;
            addr_hi_q    <= start_full[CALC_W-1:ADDR_WIDTH];
`endif
            if (i_Num_Rows == '0 || i_Num_Cols == '0) begin
              // Empty tile: finish without issuing a beat.
              state  <= S_DONE;
              o_Done <= 1'b1;
            end else begin
              state        <= S_RUN;
              beat.valid   <= 1'b1;
              beat.address <= start_full[ADDR_WIDTH-1:0];
              beat.last    <= (i_Num_Rows == INDEX_WIDTH'(1)) &&
                              (i_Num_Cols == INDEX_WIDTH'(1));
            end
          end
        end

        S_RUN: begin
          if (i_Abort) begin
            // Pending beat is dropped even if ready is high this cycle.
            state      <= S_DONE;
            o_Done     <= 1'b1;
            beat.valid <= 1'b0;
            beat.last  <= 1'b0;
          end else if (beat.valid && beat.ready) begin
`ifdef MATRIX_ADDR_OVERFLOW_CHECK_EN
            if (addr_hi_q != '0) begin
              o_Overflow <= 1'b1;
            end
            addr_hi_q <= nxt_full[CALC_W-1:ADDR_WIDTH];
`endif
            if (beat.last) begin
              state      <= S_DONE;
              o_Done     <= 1'b1;
              beat.valid <= 1'b0;
              beat.last  <= 1'b0;
            end else begin
              r_q          <= r_nxt;
              c_q          <= c_nxt;
              beat.address <= nxt_full[ADDR_WIDTH-1:0];
              beat.last    <= last_nxt;
            end
          end
        end

        S_DONE: begin
          state   <= S_IDLE;
          o_Done  <= 1'b0;
          o_Ready <= 1'b1;
        end

        default: begin
          state      <= S_IDLE;
          o_Done     <= 1'b0;
          o_Ready    <= 1'b1;
          beat.valid <= 1'b0;
          beat.last  <= 1'b0;
        end
      endcase
    end
  end

`ifndef MATRIX_ADDR_OVERFLOW_CHECK_EN
  assign o_Overflow = 1'b0;
`endif

endmodule
